fpu_multicycle: RTL and testbench

- Multicycle single-precision floating-point execution unit.
- Sits directly downstream of the controller and consumes its FPUOp encoding plus the A/B register operands.
- Performs FADD or FMUL over a fixed 5-cycle sequence.
- Returns a 32-bit result and NZCV-style flags for the result mux and flag logic, with a start/busy/done handshake so the controller FSM can stall.

---
 rtl/fpu_multicycle.sv | 207 ++++++++++++++++++++
 tb/tb_fpu_multicycle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_multicycle.sv
// Multicycle single-precision FADD/FMUL unit: IDLE->UNPACK->ALIGN->EXEC->NORM->DONE,
// five cycles from accepted start to done (LATENCY = 5), truncating rounding.
module fpu_multicycle (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  FPUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic [3:0]  FPUFlags
);

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [1:0]  OP_ADD    = 2'b01;
  localparam logic [1:0]  OP_MUL    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_EXEC   = 3'd3,
    S_NORM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        opa_q, opa_d, opb_q, opb_d;
  logic               sa_q, sa_d, sb_q, sb_d, special_q, special_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic               sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mx_q, mx_d, my_q, my_d;
  logic [47:0]        mant_q, mant_d;
  logic [31:0]        res_q, res_d;
  logic [3:0]         flags_q, flags_d;

  logic               swap_s;
  logic [7:0]         ebig_s, esml_s, diff_s;
  logic [23:0]        mbig_s, msml_s, mlo_s;
  logic [5:0]         lead_s;
  logic [47:0]        norm_s;
  logic signed [11:0] exp_adj_s;
  logic [31:0]        nres_s;
  logic               ovf_s;
  logic               unused_s;

  // Sequencer: one cycle per state, busy/done computed one cycle ahead
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_UNPACK;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UNPACK: begin state_d = S_ALIGN; busy_d = 1'b1; end
      S_ALIGN:  begin state_d = S_EXEC;  busy_d = 1'b1; end
      S_EXEC:   begin state_d = S_NORM;  busy_d = 1'b1; end
      S_NORM:   begin state_d = S_DONE;  busy_d = 1'b1; done_d = 1'b1; end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FADD alignment: larger magnitude goes to x, smaller is truncated right
  always_comb begin
    swap_s = ({ea_q, ma_q} < {eb_q, mb_q});
    ebig_s = swap_s ? eb_q : ea_q;
    esml_s = swap_s ? ea_q : eb_q;
    mbig_s = swap_s ? mb_q : ma_q;
    msml_s = swap_s ? ma_q : mb_q;
    diff_s = ebig_s - esml_s;
    mlo_s  = (diff_s >= 8'd25) ? 24'd0 : (msml_s >> diff_s);
  end

  // Normalisation: leading-one detect, exponent adjust and result selection
  always_comb begin
    lead_s = 6'd0;
    for (int i = 0; i < 48; i++) begin
      lead_s = mant_q[i] ? 6'(i) : lead_s;
    end
    norm_s    = mant_q << (6'd47 - lead_s);
    // Product binary point sits at bit 46, sum binary point at bit 23
    exp_adj_s = $signed({{2{exp_q[9]}}, exp_q}) + $signed({6'd0, lead_s})
              - ((op_q == OP_MUL) ? 12'sd46 : 12'sd23);
    unused_s  = ^{norm_s[47], norm_s[23:0]};
    nres_s    = 32'd0;
    ovf_s     = 1'b0;
    if ((op_q != OP_ADD) && (op_q != OP_MUL)) begin
      nres_s = 32'd0;
    end else if (special_q) begin
      nres_s = CANON_NAN;
      ovf_s  = 1'b1;
    end else if ((op_q == OP_MUL) && zero_q) begin
      nres_s = {sign_q, 31'd0};
    end else if (mant_q == 48'd0) begin
      nres_s = 32'd0;
    end else if (exp_adj_s >= 12'sd255) begin
      nres_s = {sign_q, 8'hFF, 23'd0};
      ovf_s  = 1'b1;
    end else if (exp_adj_s <= 12'sd0) begin
      nres_s = {sign_q, 31'd0};
    end else begin
      nres_s = {sign_q, exp_adj_s[7:0], norm_s[46:24]};
    end
  end

  // Datapath next-state: each stage updates only its own registers
  always_comb begin
    op_d = op_q;   opa_d = opa_q;   opb_d = opb_q;
    sa_d = sa_q;   sb_d = sb_q;     special_d = special_q;
    ea_d = ea_q;   eb_d = eb_q;     ma_d = ma_q;   mb_d = mb_q;
    sign_d = sign_q; sub_d = sub_q; zero_d = zero_q; exp_d = exp_q;
    mx_d = mx_q;   my_d = my_q;     mant_d = mant_q;
    res_d = res_q; flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = FPUOp;
          opa_d = SrcA;
          opb_d = SrcB;
        end else begin
          op_d  = op_q;
        end
      end
      S_UNPACK: begin
        sa_d      = opa_q[31];
        sb_d      = opb_q[31];
        ea_d      = opa_q[30:23];
        eb_d      = opb_q[30:23];
        ma_d      = (opa_q[30:23] == 8'h00) ? 24'd0 : {1'b1, opa_q[22:0]};
        mb_d      = (opb_q[30:23] == 8'h00) ? 24'd0 : {1'b1, opb_q[22:0]};
        special_d = (opa_q[30:23] == 8'hFF) || (opb_q[30:23] == 8'hFF);
      end
      S_ALIGN: begin
        if (op_q == OP_MUL) begin
          sign_d = sa_q ^ sb_q;
          exp_d  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
          mx_d   = ma_q;
          my_d   = mb_q;
          sub_d  = 1'b0;
          zero_d = (ma_q == 24'd0) || (mb_q == 24'd0);
        end else begin
          sign_d = swap_s ? sb_q : sa_q;
          exp_d  = $signed({2'b00, ebig_s});
          mx_d   = mbig_s;
          my_d   = mlo_s;
          sub_d  = sa_q ^ sb_q;
          zero_d = 1'b0;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          mant_d = {24'd0, mx_q} * {24'd0, my_q};
        end else if (sub_q) begin
          mant_d = {24'd0, mx_q} - {24'd0, my_q};
        end else begin
          mant_d = {24'd0, mx_q} + {24'd0, my_q};
        end
      end
      S_NORM: begin
        res_d   = nres_s;
        flags_d = {nres_s[31], (nres_s[30:0] == 31'd0), 1'b0, ovf_s};
      end
      S_DONE:  res_d = res_q;
      default: res_d = res_q;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;   busy_q <= 1'b0;   done_q <= 1'b0;
      op_q <= 2'd0;        opa_q <= 32'd0;   opb_q <= 32'd0;
      sa_q <= 1'b0;        sb_q <= 1'b0;     special_q <= 1'b0;
      ea_q <= 8'd0;        eb_q <= 8'd0;     ma_q <= 24'd0;   mb_q <= 24'd0;
      sign_q <= 1'b0;      sub_q <= 1'b0;    zero_q <= 1'b0;  exp_q <= 10'sd0;
      mx_q <= 24'd0;       my_q <= 24'd0;    mant_q <= 48'd0;
      res_q <= 32'd0;      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;  busy_q <= busy_d; done_q <= done_d;
      op_q <= op_d;        opa_q <= opa_d;   opb_q <= opb_d;
      sa_q <= sa_d;        sb_q <= sb_d;     special_q <= special_d;
      ea_q <= ea_d;        eb_q <= eb_d;     ma_q <= ma_d;    mb_q <= mb_d;
      sign_q <= sign_d;    sub_q <= sub_d;   zero_q <= zero_d; exp_q <= exp_d;
      mx_q <= mx_d;        my_q <= my_d;     mant_q <= mant_d;
      res_q <= res_d;      flags_q <= flags_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result   = res_q;
  assign FPUFlags = flags_q;

endmodule

// File: tb/tb_fpu_multicycle.sv
// Bench for fpu_multicycle: directed vector table, handshake corner sequences
// and random operations against a value-level truncating reference model.
module tb_fpu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  FPUOp;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] Result;
  logic [3:0]  FPUFlags;

  int checks   = 0;
  int failures = 0;

  fpu_multicycle dut (
    .clk(clk), .reset(reset), .start(start), .FPUOp(FPUOp),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .Result(Result), .FPUFlags(FPUFlags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pack sign/biased exponent/24-bit mantissa, applying overflow and underflow rules
  function automatic logic [32:0] pack(input bit s, input int e, input longint m);
    logic [31:0] r;
    if (e >= 255)    return {1'b1, s, 8'hFF, 23'd0};
    else if (e <= 0) return {1'b0, s, 31'd0};
    r = {s, 8'(e), m[22:0]};
    return {1'b0, r};
  endfunction

  // Reference: values as integer mantissa * 2^exponent, truncation everywhere
  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint ma, mb, ml, ms, m;
    int ea, eb, el, es, e;
    bit s;
    logic [32:0] p;
    if (op != 2'b01 && op != 2'b10) return {32'h0, 4'b0100};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {32'h7FC00000, 4'b0001};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
    mb = (eb == 0) ? 64'd0 : longint'({1'b1, b[22:0]});
    p  = 33'd0;
    if (op == 2'b10) begin
      s = a[31] ^ b[31];
      if (ma == 0 || mb == 0) begin
        p = {1'b0, s, 31'd0};
      end else begin
        m = ma * mb;
        e = ea + eb - 127;
        while (m >= (64'd1 << 47)) begin m = m >> 1; e++; end
        p = pack(s, e, m >> 23);
      end
    end else begin
      if (ea > eb || (ea == eb && ma >= mb)) begin
        el = ea; ml = ma; es = eb; ms = mb; s = a[31];
      end else begin
        el = eb; ml = mb; es = ea; ms = ma; s = b[31];
      end
      ms = (el - es >= 25) ? 64'd0 : (ms >> (el - es));
      m  = (a[31] == b[31]) ? ml + ms : ml - ms;
      e  = el;
      if (m == 0) begin
        p = 33'd0;
      end else begin
        while (m >= (64'd1 << 24)) begin m = m >> 1; e++; end
        while (m <  (64'd1 << 23)) begin m = m << 1; e--; end
        p = pack(s, e, m);
      end
    end
    return {p[31:0], p[31], (p[30:0] == 31'd0), 1'b0, p[32]};
  endfunction

  // Issue one operation from IDLE; inputs are scrambled after acceptance
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; FPUOp = op; SrcA = a; SrcB = b;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0; SrcA = $urandom; SrcB = $urandom; FPUOp = 2'($urandom);
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 20);
    r = Result;
    f = FPUFlags;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic [35:0] exp_v;
    logic [1:0]  op;
    logic [31:0] a, b;
    int lat, bcnt, k;
    bit seen;

    vecs[0]  = '{2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[2]  = '{2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b1000};
    vecs[3]  = '{2'b01, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0100};
    vecs[4]  = '{2'b01, 32'h4B800000, 32'h3F800000, 32'h4B800000, 4'b0000};
    vecs[5]  = '{2'b10, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0001};
    vecs[6]  = '{2'b01, 32'h7FC00001, 32'h12345678, 32'h7FC00000, 4'b0001};
    vecs[7]  = '{2'b00, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0100};
    vecs[8]  = '{2'b11, 32'h40000000, 32'h40400000, 32'h00000000, 4'b0100};
    vecs[9]  = '{2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b1100};
    vecs[10] = '{2'b01, 32'h00400000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[11] = '{2'b10, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0100};
    vecs[12] = '{2'b01, 32'h40400000, 32'hC0000000, 32'h3F800000, 4'b0000};
    vecs[13] = '{2'b01, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0001};
    vecs[14] = '{2'b01, 32'hBF800000, 32'h3F000000, 32'hBF000000, 4'b1000};
    vecs[15] = '{2'b01, 32'h3F800000, 32'hB3800000, 32'h3F800000, 4'b0000};
    vecs[16] = '{2'b01, 32'h3F800000, 32'h34000000, 32'h3F800001, 4'b0000};

    reset = 1'b0; start = 1'b0; FPUOp = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    chk("reset_flags", {28'd0, FPUFlags}, 32'd0);
    reset = 1'b1;

    // Directed table, issued back-to-back in the IDLE cycle after each done
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, bcnt);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {28'd0, f}, {28'd0, vecs[i].flg});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd5);
    end

    // Start while busy is ignored; first operation's result returned
    @(negedge clk);
    start = 1'b1; FPUOp = 2'b01; SrcA = 32'h3F800000; SrcB = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; FPUOp = 2'b10; SrcA = 32'h7F000000; SrcB = 32'h7F000000;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("busy_start_latency", 32'(lat), 32'd5);
    chk("busy_start_result", Result, 32'h40400000);
    chk("busy_start_flags", {28'd0, FPUFlags}, 32'd0);
    @(negedge clk);
    chk("after_done_busy", {31'd0, busy}, 32'd0);
    chk("after_done_done", {31'd0, done}, 32'd0);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen = seen | done | busy; end
    chk("no_second_op", {31'd0, seen}, 32'd0);
    chk("result_held", Result, 32'h40400000);

    // Reset while in EXEC aborts the operation
    @(negedge clk);
    start = 1'b1; FPUOp = 2'b10; SrcA = 32'h3FC00000; SrcB = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", Result, 32'd0);
    chk("abort_flags", {28'd0, FPUFlags}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | done; end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    run_op(2'b10, 32'hC0000000, 32'h40400000, r, f, lat, bcnt);
    chk("post_abort_latency", 32'(lat), 32'd5);
    chk("post_abort_result", r, 32'hC0C00000);
    chk("post_abort_flags", {28'd0, f}, 32'h8);

    // Random operations against the reference model
    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 9);
      op = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : (k < 6) ? 2'b01 : 2'b10;
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 15) == 0) a[30:23] = 8'd0;
      if (i % 2 == 1) b[30:23] = a[30:23] - 8'($urandom_range(0, 26));
      if ($urandom_range(0, 1) == 1) begin
        r = a; a = b; b = r;
      end
      exp_v = model(op, a, b);
      run_op(op, a, b, r, f, lat, bcnt);
      if (r !== exp_v[35:4] || f !== exp_v[3:0])
        $display("  op=%b a=%h b=%h", op, a, b);
      chk("rand_result", r, exp_v[35:4]);
      chk("rand_flags", {28'd0, f}, {28'd0, exp_v[3:0]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
